// File: rtl/uart_cmd_exec_pkg.sv
// Shared definitions for the UART command executor: FSM state codes, ASCII
// constants for command keywords and responses, and the address-width helper.
package uart_cmd_exec_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_HDR      = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_RESP_OK  = 4'd3;
    localparam logic [3:0] ST_RESP_RD  = 4'd4;
    localparam logic [3:0] ST_RESP_REV = 4'd5;
    localparam logic [3:0] ST_RESP_ERR = 4'd6;
    localparam logic [3:0] ST_RESP_NL  = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    localparam logic [7:0]  CH_CR       = 8'h0D;
    localparam logic [7:0]  CH_LF       = 8'h0A;
    localparam logic [7:0]  CH_BS       = 8'h08;
    localparam logic [31:0] STR_LED_CMD = "led ";
    localparam logic [15:0] STR_RD      = "rd";
    localparam logic [31:0] STR_REV     = "rev ";
    localparam logic [15:0] STR_OK      = "OK";
    localparam logic [23:0] STR_ERR     = "ERR";
    localparam logic [31:0] STR_LED_RSP = "LED=";

    // Bit count of (len-1) plus one, so a length equal to the depth still fits.
    function automatic int aw_of(input int len);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if (((len - 1) >> i) != 0) n = i + 1;
        end
        return n + 1;
    endfunction

endpackage

// File: rtl/uart_cmd_exec_hex_ascii.sv
// Combinational hex helper: nibble to uppercase ASCII digit, and ASCII hex
// digit (0-9, a-f, A-F) to nibble with a validity flag.
module uart_cmd_exec_hex_ascii (
    input  logic [3:0] nib,
    input  logic [7:0] asc,
    output logic [7:0] asc_out,
    output logic [3:0] nib_out,
    output logic       nib_valid
);

    always_comb begin
        asc_out   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        nib_out   = 4'h0;
        nib_valid = 1'b0;
        if (asc >= "0" && asc <= "9") begin
            nib_out   = 4'(asc - 8'h30);
            nib_valid = 1'b1;
        end else if (asc >= "a" && asc <= "f") begin
            nib_out   = 4'(asc - 8'h57);
            nib_valid = 1'b1;
        end else if (asc >= "A" && asc <= "F") begin
            nib_out   = 4'(asc - 8'h37);
            nib_valid = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_exec.sv
// Command executor: reads a command line from the shared line RAM, decodes
// "led XY", "rd" and "rev <text>", and writes a CR/LF-terminated response.
module uart_cmd_exec
    import uart_cmd_exec_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEN        = 256,
    parameter int RXSTR_BASE = 0,
    parameter int TXSTR_BASE = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    input  logic [aw_of(LEN)-1:0]   cmd_len,
    output logic                    msg_valid,
    output logic [aw_of(LEN)-1:0]   msg_len,
    output logic [aw_of(LEN)-1:0]   addr,
    output logic [WIDTH-1:0]        din,
    input  logic [WIDTH-1:0]        dout,
    output logic                    we,
    output logic [7:0]              led
);

    localparam int AW = aw_of(LEN);
    localparam logic [AW-1:0] RX0     = AW'(RXSTR_BASE);
    localparam logic [AW-1:0] TX0     = AW'(TXSTR_BASE);
    localparam logic [AW-1:0] REV_CAP = AW'(LEN - TXSTR_BASE - 2);

    logic [3:0]       state;
    logic [2:0]       cnt;
    logic             ph;
    logic [AW-1:0]    len_q;
    logic [AW-1:0]    widx;
    logic [AW-1:0]    rev_n;
    logic [7:0]       hdr [4];
    logic [31:0]      hdr_word;
    logic [7:0]       arg_hi;
    logic [7:0]       arg_lo;
    logic [WIDTH-1:0] din_q;
    logic             din_sel;
    logic [7:0]       resp_byte;
    logic [7:0]       led_hi_asc;
    logic [7:0]       led_lo_asc;
    logic [3:0]       arg_hi_nib;
    logic [3:0]       arg_lo_nib;
    logic             arg_hi_ok;
    logic             arg_lo_ok;

    uart_cmd_exec_hex_ascii u_hex_hi (
        .nib       (led[7:4]),
        .asc       (arg_hi),
        .asc_out   (led_hi_asc),
        .nib_out   (arg_hi_nib),
        .nib_valid (arg_hi_ok)
    );

    uart_cmd_exec_hex_ascii u_hex_lo (
        .nib       (led[3:0]),
        .asc       (arg_lo),
        .asc_out   (led_lo_asc),
        .nib_out   (arg_lo_nib),
        .nib_valid (arg_lo_ok)
    );

    assign hdr_word = {hdr[0], hdr[1], hdr[2], hdr[3]};

    // Reversal forwards the RAM read data straight into the write cycle so
    // each byte costs only one read cycle plus one write cycle.
    assign din = din_sel ? dout : din_q;

    always_comb begin
        resp_byte = 8'h00;
        case (state)
            ST_RESP_OK: resp_byte = (cnt == 3'd3) ? STR_OK[15:8] : STR_OK[7:0];
            ST_RESP_RD: begin
                case (cnt)
                    3'd0:    resp_byte = STR_LED_RSP[31:24];
                    3'd1:    resp_byte = STR_LED_RSP[23:16];
                    3'd2:    resp_byte = STR_LED_RSP[15:8];
                    3'd3:    resp_byte = STR_LED_RSP[7:0];
                    3'd4:    resp_byte = led_hi_asc;
                    default: resp_byte = led_lo_asc;
                endcase
            end
            ST_RESP_ERR: begin
                case (cnt)
                    3'd0:    resp_byte = STR_ERR[23:16];
                    3'd1:    resp_byte = STR_ERR[15:8];
                    default: resp_byte = STR_ERR[7:0];
                endcase
            end
            ST_RESP_NL: resp_byte = ph ? CH_LF : CH_CR;
            default:    resp_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            msg_valid <= 1'b0;
            msg_len   <= '0;
            we        <= 1'b0;
            addr      <= '0;
            din_q     <= '0;
            din_sel   <= 1'b0;
            led       <= 8'h00;
            cnt       <= '0;
            ph        <= 1'b0;
            widx      <= '0;
        end else begin
            we        <= 1'b0;
            msg_valid <= 1'b0;
            din_sel   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len_q <= cmd_len;
                        addr  <= RX0;
                        cnt   <= '0;
                        state <= ST_HDR;
                    end
                end
                // Reads issued at cnt 0..3 land in hdr one cycle later (cnt 1..4).
                ST_HDR: begin
                    if (cnt != 3'd0)
                        hdr[cnt[1:0] - 2'd1] <= (AW'(cnt - 3'd1) < len_q) ? dout[7:0] : 8'h00;
                    if (cnt < 3'd3)
                        addr <= RX0 + AW'(cnt) + AW'(1);
                    if (cnt == 3'd4)
                        state <= ST_DECODE;
                    cnt <= cnt + 3'd1;
                end
                ST_DECODE: begin
                    cnt   <= '0;
                    ph    <= 1'b0;
                    widx  <= '0;
                    rev_n <= (len_q - AW'(4) > REV_CAP) ? REV_CAP : len_q - AW'(4);
                    addr  <= RX0 + len_q - AW'(1);
                    if (len_q == '0) begin
                        state <= ST_RESP_NL;
                    end else if (len_q == AW'(6) && hdr_word == STR_LED_CMD) begin
                        state <= ST_RESP_OK;
                        addr  <= RX0 + AW'(4);
                    end else if (len_q == AW'(2) && hdr_word[31:16] == STR_RD) begin
                        state <= ST_RESP_RD;
                    end else if (len_q >= AW'(4) && hdr_word == STR_REV) begin
                        state <= ST_RESP_REV;
                    end else begin
                        state <= ST_RESP_ERR;
                    end
                end
                ST_RESP_OK: begin
                    cnt <= cnt + 3'd1;
                    case (cnt)
                        3'd0: addr   <= RX0 + AW'(5);
                        3'd1: arg_hi <= dout[7:0];
                        3'd2: arg_lo <= dout[7:0];
                        3'd3: begin
                            if (arg_hi_ok && arg_lo_ok) begin
                                led   <= {arg_hi_nib, arg_lo_nib};
                                addr  <= TX0 + widx;
                                din_q <= WIDTH'(resp_byte);
                                we    <= 1'b1;
                                widx  <= widx + AW'(1);
                            end else begin
                                state <= ST_RESP_ERR;
                                cnt   <= '0;
                            end
                        end
                        default: begin
                            addr  <= TX0 + widx;
                            din_q <= WIDTH'(resp_byte);
                            we    <= 1'b1;
                            widx  <= widx + AW'(1);
                            ph    <= 1'b0;
                            state <= ST_RESP_NL;
                        end
                    endcase
                end
                ST_RESP_RD, ST_RESP_ERR: begin
                    addr  <= TX0 + widx;
                    din_q <= WIDTH'(resp_byte);
                    we    <= 1'b1;
                    widx  <= widx + AW'(1);
                    cnt   <= cnt + 3'd1;
                    if ((state == ST_RESP_RD && cnt == 3'd5) || (state == ST_RESP_ERR && cnt == 3'd2)) begin
                        ph    <= 1'b0;
                        state <= ST_RESP_NL;
                    end
                end
                // ph=0: source read on the bus; ph=1: write with forwarded data.
                ST_RESP_REV: begin
                    if (!ph) begin
                        if (widx == rev_n) begin
                            state <= ST_RESP_NL;
                        end else begin
                            addr    <= TX0 + widx;
                            we      <= 1'b1;
                            din_sel <= 1'b1;
                            ph      <= 1'b1;
                        end
                    end else begin
                        din_q <= dout;
                        widx  <= widx + AW'(1);
                        addr  <= RX0 + len_q - AW'(2) - widx;
                        ph    <= 1'b0;
                    end
                end
                ST_RESP_NL: begin
                    addr  <= TX0 + widx;
                    din_q <= WIDTH'(resp_byte);
                    we    <= 1'b1;
                    widx  <= widx + AW'(1);
                    ph    <= 1'b1;
                    if (ph)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    msg_valid <= 1'b1;
                    msg_len   <= widx;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_exec.sv
// Bench for uart_cmd_exec: RAM model plus a string-level reference of the
// command set, driven with directed and randomized command lines.
module tb_uart_cmd_exec;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [8:0] cmd_len;
    logic       msg_valid;
    logic [8:0] msg_len;
    logic [8:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       we;
    logic [7:0] led;

    logic [7:0] mem [0:511];
    logic       ld_en;
    logic [8:0] ld_addr;
    logic [7:0] ld_data;
    int         we_cnt;
    int         bad_wr;
    int         mv_cnt;

    logic [7:0] img  [0:511];
    logic [7:0] cbuf [0:255];
    logic [7:0] exp_q [$];
    logic [7:0] model_led;
    int         checks;
    int         errors;

    uart_cmd_exec #(.WIDTH(8), .LEN(256), .RXSTR_BASE(0), .TXSTR_BASE(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_len   (cmd_len),
        .msg_valid (msg_valid),
        .msg_len   (msg_len),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .we        (we),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (we) mem[addr] <= din;
        dout <= mem[addr];
        if (we) begin
            we_cnt <= we_cnt + 1;
            if (addr >= 9'd256 || addr < 9'd128) bad_wr <= bad_wr + 1;
        end
        if (msg_valid) mv_cnt <= mv_cnt + 1;
    end

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Reference: response text from the command string and the led register.
    task automatic model_cmd(input int len);
        string hx;
        int hi, lo, n;
        logic [7:0] b;
        hx = "0123456789ABCDEF";
        exp_q.delete();
        if (len == 0) begin
        end else if (len == 6 && img[0] == "l" && img[1] == "e" && img[2] == "d" && img[3] == " ") begin
            hi = hexval(img[4]);
            lo = hexval(img[5]);
            if (hi >= 0 && lo >= 0) begin
                model_led = 8'(hi * 16 + lo);
                exp_q.push_back("O"); exp_q.push_back("K");
            end else begin
                exp_q.push_back("E"); exp_q.push_back("R"); exp_q.push_back("R");
            end
        end else if (len == 2 && img[0] == "r" && img[1] == "d") begin
            exp_q.push_back("L"); exp_q.push_back("E"); exp_q.push_back("D"); exp_q.push_back("=");
            exp_q.push_back(8'(hx[model_led / 16]));
            exp_q.push_back(8'(hx[model_led % 16]));
        end else if (len >= 4 && img[0] == "r" && img[1] == "e" && img[2] == "v" && img[3] == " ") begin
            n = len - 4;
            if (n > 126) n = 126;
            for (int i = 0; i < n; i++) begin
                b = img[len - 1 - i];
                img[128 + i] = b;
                exp_q.push_back(b);
            end
        end else begin
            exp_q.push_back("E"); exp_q.push_back("R"); exp_q.push_back("R");
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic set_str(input string s);
        for (int i = 0; i < s.len(); i++) cbuf[i] = s[i];
    endtask

    task automatic ld_put(input int a, input logic [7:0] b);
        ld_en = 1'b1; ld_addr = 9'(a); ld_data = b;
        @(posedge clk); #1;
    endtask

    task automatic prep(input int len);
        for (int i = 128; i < 256; i++) begin
            img[i] = 8'($urandom);
            ld_put(i, img[i]);
        end
        for (int i = 0; i < len; i++) begin
            img[i] = cbuf[i];
            ld_put(i, cbuf[i]);
        end
        ld_en = 1'b0;
    endtask

    task automatic run_cmd(input string name, input int len, input int glitch_at);
        int wb, bb, mb, cyc;
        bit seen;
        logic [8:0] ml;
        prep(len);
        model_cmd(len);
        wb = we_cnt; bb = bad_wr; mb = mv_cnt;
        cmd_valid = 1'b1; cmd_len = 9'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_len = 9'($urandom);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 2 * len + 40) begin
            @(posedge clk); cyc++; #1;
            if (glitch_at != 0 && cyc == glitch_at) begin
                cmd_valid = 1'b1; cmd_len = 9'd1;
            end else begin
                cmd_valid = 1'b0;
            end
            if (msg_valid) seen = 1'b1;
        end
        cmd_valid = 1'b0;
        checks++;
        if (!seen) begin
            $display("FAIL %s timeout: no msg_valid after %0d cycles", name, cyc);
            errors++;
            return;
        end
        checks++;
        if (cyc > 2 * len + 16) begin
            $display("FAIL %s latency: got %0d cycles, limit %0d", name, cyc, 2 * len + 16);
            errors++;
        end
        checks++;
        if (msg_len !== 9'(exp_q.size())) begin
            $display("FAIL %s msg_len: got %0d want %0d", name, msg_len, exp_q.size());
            errors++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (mem[128 + i] !== exp_q[i]) begin
                $display("FAIL %s byte %0d: got %h want %h", name, i, mem[128 + i], exp_q[i]);
                errors++;
            end
        end
        ml = msg_len;
        @(posedge clk); #1;
        checks++;
        if (msg_valid !== 1'b0) begin
            $display("FAIL %s msg_valid width: got %b want 0 on second cycle", name, msg_valid);
            errors++;
        end
        checks++;
        if (msg_len !== ml) begin
            $display("FAIL %s msg_len hold: got %0d want %0d", name, msg_len, ml);
            errors++;
        end
        checks++;
        if (we_cnt - wb != exp_q.size()) begin
            $display("FAIL %s we pulses: got %0d want %0d", name, we_cnt - wb, exp_q.size());
            errors++;
        end
        checks++;
        if (bad_wr != bb) begin
            $display("FAIL %s write range: got %0d stray writes want 0", name, bad_wr - bb);
            errors++;
        end
        checks++;
        if (mv_cnt - mb != 1) begin
            $display("FAIL %s msg_valid count: got %0d want 1", name, mv_cnt - mb);
            errors++;
        end
        checks++;
        if (led !== model_led) begin
            $display("FAIL %s led: got %h want %h", name, led, model_led);
            errors++;
        end
    endtask

    task automatic test_reset;
        int wb, mb;
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (msg_valid !== 1'b0) begin $display("FAIL reset msg_valid: got %b want 0", msg_valid); errors++; end
        checks++; if (msg_len !== 9'd0) begin $display("FAIL reset msg_len: got %0d want 0", msg_len); errors++; end
        checks++; if (we !== 1'b0) begin $display("FAIL reset we: got %b want 0", we); errors++; end
        checks++; if (addr !== 9'd0) begin $display("FAIL reset addr: got %0d want 0", addr); errors++; end
        checks++; if (din !== 8'h00) begin $display("FAIL reset din: got %h want 00", din); errors++; end
        checks++; if (led !== 8'h00) begin $display("FAIL reset led: got %h want 00", led); errors++; end
        // cmd_valid together with rst must be dropped
        wb = we_cnt; mb = mv_cnt;
        cmd_valid = 1'b1; cmd_len = 9'd2;
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (we_cnt != wb) begin $display("FAIL reset priority we: got %0d writes want 0", we_cnt - wb); errors++; end
        checks++; if (mv_cnt != mb) begin $display("FAIL reset priority msg_valid: got %0d want 0", mv_cnt - mb); errors++; end
        model_led = 8'h00;
    endtask

    task automatic test_led_set;
        set_str("led 5A");
        run_cmd("led_5A", 6, 0);
        checks++; if (led !== 8'h5A) begin $display("FAIL led_5A value: got %h want 5a", led); errors++; end
    endtask

    task automatic test_rd;
        set_str("rd");
        run_cmd("rd", 2, 0);
        checks++; if (msg_len !== 9'd8) begin $display("FAIL rd length: got %0d want 8", msg_len); errors++; end
    endtask

    task automatic test_rev;
        set_str("rev abc");
        run_cmd("rev_abc", 7, 0);
        set_str("rev ");
        run_cmd("rev_empty", 4, 0);
    endtask

    task automatic test_errors;
        set_str("led 5G");
        run_cmd("led_5G", 6, 0);
        set_str("xyz");
        run_cmd("xyz", 3, 0);
        set_str("led 5a");
        run_cmd("led_len7", 7, 0);
        checks++; if (led !== 8'h5A) begin $display("FAIL err led kept: got %h want 5a", led); errors++; end
    endtask

    task automatic test_empty;
        run_cmd("empty", 0, 0);
    endtask

    task automatic test_rev_long;
        set_str("rev ");
        for (int i = 4; i < 204; i++) cbuf[i] = 8'($urandom_range(97, 122));
        run_cmd("rev_long", 204, 0);
        checks++; if (msg_len !== 9'd128) begin $display("FAIL rev_long cap: got %0d want 128", msg_len); errors++; end
    endtask

    task automatic test_busy_cmd;
        set_str("rev hello");
        run_cmd("busy_glitch", 9, 4);
    endtask

    task automatic test_random;
        string pool;
        int t, len, m;
        pool = "0123456789abcdefABCDEFgGz:/@~";
        for (int k = 0; k < 16; k++) begin
            t = $urandom_range(0, 4);
            len = 0;
            case (t)
                0: begin
                    set_str("led ");
                    cbuf[4] = 8'(pool[$urandom_range(0, pool.len() - 1)]);
                    cbuf[5] = 8'(pool[$urandom_range(0, pool.len() - 1)]);
                    len = 6;
                end
                1: begin set_str("rd"); len = 2; end
                2: begin
                    set_str("rev ");
                    m = $urandom_range(0, 40);
                    for (int i = 0; i < m; i++) cbuf[4 + i] = 8'($urandom_range(32, 126));
                    len = 4 + m;
                end
                3: begin
                    len = $urandom_range(0, 8);
                    for (int i = 0; i < len; i++) cbuf[i] = 8'($urandom_range(97, 122));
                end
                default: begin
                    set_str("led ");
                    for (int i = 4; i < 8; i++) cbuf[i] = 8'(pool[$urandom_range(0, 15)]);
                    len = $urandom_range(5, 8);
                end
            endcase
            run_cmd($sformatf("rnd%0d", k), len, (k % 3 == 0) ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid_rev;
        int wb, mb;
        set_str("rev abcdefghijklmnopqrst");
        prep(24);
        cmd_valid = 1'b1; cmd_len = 9'd24;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        wb = we_cnt; mb = mv_cnt;
        checks++; if (we !== 1'b0) begin $display("FAIL midrst we: got %b want 0", we); errors++; end
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (we_cnt != wb) begin $display("FAIL midrst writes: got %0d want 0", we_cnt - wb); errors++; end
        checks++; if (mv_cnt != mb) begin $display("FAIL midrst msg_valid: got %0d want 0", mv_cnt - mb); errors++; end
        checks++; if (led !== 8'h00) begin $display("FAIL midrst led: got %h want 00", led); errors++; end
        model_led = 8'h00;
        set_str("rd");
        run_cmd("rd_after_rst", 2, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        we_cnt = 0; bad_wr = 0; mv_cnt = 0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        model_led = 8'h00;
        for (int i = 0; i < 512; i++) begin mem[i] = 8'h00; img[i] = 8'h00; end
        test_reset();
        test_led_set();
        test_rd();
        test_rev();
        test_errors();
        test_empty();
        test_rev_long();
        test_busy_cmd();
        test_random();
        test_reset_mid_rev();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
